// File: rtl/seg_disp_sched.sv
// seg_disp_sched
//   Display scheduler placed in front of a 6-digit 7-segment scan driver.
//   It shares the 24-bit display value between a live background source and
//   two message requesters. A has priority over B. A granted message stays on
//   screen for HOLD_MS hold-timer ticks. After that the display returns to the
//   background.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   bg_data   background value, shown (1-cycle delayed) while idle
//   a_req     requester A level request (high priority)
//   a_data    A message, captured in the grant cycle
//   a_ack     one-cycle pulse in the cycle A is granted
//   b_req     requester B level request (low priority)
//   b_data    B message, captured in the grant cycle
//   b_ack     one-cycle pulse in the cycle B is granted
//   data_out  registered value to the scan driver
//   owner     00 background, 01 A, 10 B
//   busy      high while a message is held
module seg_disp_sched #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned HOLD_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] bg_data,
  input  logic        a_req,
  input  logic [23:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [23:0] b_data,
  output logic        b_ack,
  output logic [23:0] data_out,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int unsigned TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]   HOLD_END  = 16'(HOLD_MS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW_A = 2'b01,
    SHOW_B = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   hold_q,  hold_d;
  logic [23:0]   data_q,  data_d;
  logic [1:0]    owner_q, owner_d;
  logic          busy_q,  busy_d;

  logic tick;
  logic expire;
  logic grant_a;
  logic grant_b;

  // Free-running tick prescaler; grants never realign it, which is why the
  // hold time can be up to one tick longer than HOLD_MS ticks.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // The counter only advances on a tick, and it stops at HOLD_END. The first
  // tick after a grant moves it off zero. Expiry is detected on the tick that
  // arrives while the count is already at HOLD_END.
  always_comb begin
    expire = (state_q != IDLE) && tick && (hold_q == HOLD_END);
  end

  // Grant decision per state. A is granted in every state. B can preempt no
  // one, and while A is showing B waits until A's hold expires.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          grant_a = a_req;
          grant_b = !a_req && b_req;
        end
        SHOW_A: begin
          grant_a = a_req;
          grant_b = !a_req && b_req && expire;
        end
        SHOW_B: begin
          grant_a = a_req;
          grant_b = !a_req && b_req;
        end
        default: begin
          grant_a = 1'b0;
          grant_b = 1'b0;
        end
      endcase
    end
  end

  // Next state, hold counter and registered display outputs. A grant in the
  // same cycle as an expiry takes precedence. The counter reloads and the
  // display never passes through an idle cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;

    if (grant_a) begin
      state_d = SHOW_A;
      hold_d  = '0;
      data_d  = a_data;
    end else if (grant_b) begin
      state_d = SHOW_B;
      hold_d  = '0;
      data_d  = b_data;
    end else if (expire) begin
      state_d = IDLE;
      data_d  = bg_data;
    end else begin
      unique case (state_q)
        IDLE: begin
          data_d = bg_data;
        end
        SHOW_A, SHOW_B: begin
          if (tick && (hold_q != HOLD_END)) begin
            hold_d = hold_q + 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = bg_data;
        end
      endcase
    end

    owner_d = state_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign a_ack    = grant_a;
  assign b_ack    = grant_b;
  assign data_out = data_q;
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched
//   Scoreboard bench for seg_disp_sched. It uses CLK_HZ=10_000 and
//   TICK_HZ=1000, so the hold timer ticks every 10 clocks. HOLD_MS is 3.
//   The driver applies inputs on the falling edge. A reference model then
//   pushes the expected acks and post-edge outputs. A monitor pops each
//   entry and compares it with the DUT.
module tb_seg_disp_sched;

  localparam int unsigned DIV  = 10;
  localparam int unsigned HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] bg_data, a_data, b_data, data_out;
  logic        a_req, b_req, a_ack, b_ack, busy;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  seg_disp_sched #(
    .CLK_HZ (10_000),
    .TICK_HZ(1000),
    .HOLD_MS(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bg_data (bg_data),
    .a_req   (a_req),
    .a_data  (a_data),
    .a_ack   (a_ack),
    .b_req   (b_req),
    .b_data  (b_data),
    .b_ack   (b_ack),
    .data_out(data_out),
    .owner   (owner),
    .busy    (busy)
  );

  typedef struct packed {
    logic        a_ack;
    logic        b_ack;
    logic [23:0] data;
    logic [1:0]  owner;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model state.
  // m_owner: 0 = background, 1 = A, 2 = B.
  // m_ticks: ticks seen since the grant.
  int          m_owner = 0;
  int          m_ticks = 0;
  int          m_presc = 0;
  logic [23:0] m_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the model and queue the expectation.
  task automatic step(input logic r, input logic ra, input logic rb,
                      input logic [23:0] ad, input logic [23:0] bd, input logic [23:0] bg);
    exp_t e;
    bit   tck, exp_now, ea, eb;
    @(negedge clk);
    rst = r; a_req = ra; b_req = rb; a_data = ad; b_data = bd; bg_data = bg;
    ea = 0; eb = 0;
    if (r) begin
      m_owner = 0; m_ticks = 0; m_presc = 0; m_data = '0;
    end else begin
      tck     = (m_presc == DIV - 1);
      // A message expires on the tick that would take it past HOLD full ticks.
      exp_now = (m_owner != 0) && tck && (m_ticks == HOLD);
      ea = ra;
      if (m_owner == 1) eb = !ra && rb && exp_now;
      else              eb = !ra && rb;
      if (ea) begin
        m_owner = 1; m_data = ad; m_ticks = 0;
      end else if (eb) begin
        m_owner = 2; m_data = bd; m_ticks = 0;
      end else if (exp_now || m_owner == 0) begin
        m_owner = 0; m_data = bg;
      end else if (tck) begin
        m_ticks++;
      end
      m_presc = (m_presc + 1) % DIV;
    end
    e.a_ack = ea;
    e.b_ack = eb;
    e.data  = m_data;
    e.owner = 2'(m_owner);
    e.busy  = (m_owner != 0);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 24'h0, 24'h0, 24'($urandom));
  endtask

  // Monitor. Acks are combinational, so they are sampled mid-cycle. The
  // registered outputs are sampled just after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("a_ack", 32'(a_ack), 32'(e.a_ack));
        check("b_ack", 32'(b_ack), 32'(e.b_ack));
        check("ack_onehot", 32'(a_ack & b_ack), 32'(0));
        @(posedge clk);
        #1;
        check("data_out", 32'(data_out), 32'(e.data));
        check("owner", 32'(owner), 32'(e.owner));
        check("busy", 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin
    int n;
    int k;
    rst = 1; a_req = 0; b_req = 0; a_data = '0; b_data = '0; bg_data = 24'h000042;

    // Reset, then release and show the live background.
    step(1, 0, 0, 0, 0, 24'h000042);
    step(1, 0, 0, 0, 0, 24'h000042);
    step(0, 0, 0, 0, 0, 24'h000042);
    step(0, 0, 0, 0, 0, 24'h000042);
    idle(3);

    // A alone. Busy must last 30..40 clocks.
    step(0, 1, 0, 24'hA1A1A1, 0, 24'h000042);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 0, 0, 24'($urandom));
      if (busy) n++;
      else break;
    end
    total++;
    if (n < 30 || n > 40) begin
      bad++;
      $display("FAIL a_hold_len: got %0d clk want 30..40", n);
    end
    idle(4);

    // Priority: A and B together. B stays high until it is granted at A's expiry.
    step(0, 1, 1, 24'hAAAA01, 24'hBBBB01, 24'h1);
    k = 0;
    while (m_owner != 2 && k < 60) begin
      step(0, 0, 1, 0, 24'hBBBB01, 24'h2);
      k++;
    end
    check("b_granted_after_a", 32'(m_owner == 2), 32'(1));
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 0, 0, 24'h3);
      if (busy) n++;
      else break;
    end
    total++;
    if (n < 30 || n > 40) begin
      bad++;
      $display("FAIL b_hold_len: got %0d clk want 30..40", n);
    end
    idle(3);

    // Preempt: B showing, then A arrives on clock 5 of B's hold.
    step(0, 0, 1, 0, 24'hB0B0B0, 24'h4);
    idle(4);
    step(0, 1, 0, 24'hA5A5A5, 0, 24'h5);
    step(0, 0, 0, 0, 0, 24'h6);
    check("preempt_owner", 32'(owner), 32'(1));
    check("preempt_data", 32'(data_out), 32'h00A5A5A5);
    idle(45);

    // Retrigger: A showing, then A again at hold count 2.
    step(0, 1, 0, 24'hA2A2A2, 0, 24'h7);
    k = 0;
    while (m_ticks != 2 && k < 40) begin
      idle(1);
      k++;
    end
    step(0, 1, 0, 24'h123456, 0, 24'h8);
    idle(50);

    // Reset during SHOW_A with B pending. Nothing is remembered across
    // reset, so B is granted right after release.
    step(0, 1, 0, 24'hA3A3A3, 0, 24'h9);
    idle(5);
    step(1, 0, 1, 0, 24'hB3B3B3, 24'h0000AB);
    step(1, 0, 1, 0, 24'hB3B3B3, 24'h0000AB);
    step(0, 0, 1, 0, 24'hB3B3B3, 24'h0000AB);
    idle(45);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(399) == 0), ($urandom_range(15) == 0), ($urandom_range(5) == 0),
           24'($urandom), 24'($urandom), 24'($urandom));
    end

    idle(2);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
